uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one uart_tx (range 2..8).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving the character width; it SHALL match the uart_tx instance.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, giving the maximum number of clk cycles WAIT_DONE waits for tx_done.
REQ-004 Port clk, input, 1 bit: the single clock.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port req, input, NUM_REQ bits: per-requester transmit request, level.
REQ-007 Port req_data, input, NUM_REQ x DATA_BITS: per-requester character.
REQ-008 Port grant, output, NUM_REQ bits: one-hot, one-cycle pulse; data captured.
REQ-009 Port done, output, NUM_REQ bits: one-hot, one-cycle pulse; owner's character finished or aborted.
REQ-010 Port tx_start, output, 1 bit: one-cycle start pulse to uart_tx.
REQ-011 Port tx_data, output, DATA_BITS: character to uart_tx, registered.
REQ-012 Port tx_done, input, 1 bit: completion pulse from uart_tx.
REQ-013 Port tx_busy, input, 1 bit: uart_tx busy level.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.
REQ-015 Port timeout_err, output, 1 bit: one-cycle pulse on watchdog abort.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT, START and WAIT_DONE.
REQ-017 IDLE with req nonzero at cycle t SHALL move to GRANT at t+1, with grant[w] high, tx_data = req_data[w] and owner = w, where w is the round-robin winner sampled at t.
REQ-018 The winner SHALL be the first set req bit at index ptr, ptr+1, ... with wrap-around modulo NUM_REQ.
REQ-019 GRANT SHALL last exactly one cycle and then move to START.
REQ-020 START SHALL assert tx_start for exactly one cycle, in the first cycle where tx_busy is 0, and move to WAIT_DONE in the next cycle; while tx_busy is 1, START SHALL hold with tx_start low.
REQ-021 In WAIT_DONE, tx_done SHALL produce done[owner] in the next cycle, set ptr = (owner+1) mod NUM_REQ, and return to IDLE.
REQ-022 The watchdog counter SHALL clear on entry to WAIT_DONE; when it reaches TIMEOUT_CYCLES without tx_done, the block SHALL pulse timeout_err and done[owner] together, advance ptr as in REQ-021, and return to IDLE.
REQ-023 tx_done received in any state other than WAIT_DONE SHALL be ignored.
REQ-024 tx_data SHALL hold its value from GRANT until the next GRANT.
REQ-025 Requesters SHALL hold req and req_data until grant; a req still high after its done SHALL re-arbitrate as a new request.
REQ-026 A req bit dropping before grant SHALL NOT be granted; the winner is decided only from the IDLE sample.
REQ-027 Minimum request-to-tx_start latency SHALL be 2 cycles.
REQ-028 The block SHALL hold at most one character in flight.

Reset
REQ-029 On rst, state SHALL go to IDLE and ptr, owner, tx_data and the watchdog counter SHALL go to 0.
REQ-030 On rst, grant, done, tx_start, busy and timeout_err SHALL be 0.
REQ-031 rst asserted mid-transfer SHALL abort without a done pulse; rst SHALL override all other inputs.

Structure
REQ-032 Package uart_ctrl_pkg SHALL hold the state enum typedef sched_state_t and the default constants for NUM_REQ, DATA_BITS and TIMEOUT_CYCLES.
REQ-033 Sub-module uart_rr_pick SHALL be a combinational round-robin picker with inputs req and ptr and outputs one-hot winner and valid.
REQ-034 uart_tx_scheduler SHALL be placed between the requesters and uart_tx, alongside the existing baud generator, uart_tx and uart_rx.

Verification (NUM_REQ=4, DATA_BITS=8, TIMEOUT_CYCLES=16)
REQ-035 Single request: req=0001, req_data[0]=8'hA5 -> grant=0001 at t+1, tx_start at t+2 with tx_data=A5, done=0001 the cycle after tx_done.
REQ-036 Contention: req=1111 held from ptr=0 -> grants in order 0,1,2,3,0; each tx_start occurs only after the previous done.
REQ-037 Wrap: ptr=3, req=0101 -> grant requester 0, then ptr=1, then requester 2.
REQ-038 Busy hold: tx_busy=1 for 5 cycles after GRANT -> tx_start held low, asserted in the first cycle after tx_busy falls, exactly one pulse.
REQ-039 Timeout: tx_done never arrives -> timeout_err and done[owner] pulse 16 cycles after WAIT_DONE entry, busy falls next cycle, stray tx_done afterwards is ignored.
REQ-040 Reset mid-WAIT_DONE -> all outputs 0 the next cycle, no done pulse, ptr=0, next req=0010 granted normally.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and default parameters for the UART transmit scheduler.
// Imported by the round-robin picker and the scheduler top.
package uart_ctrl_pkg;

    localparam int unsigned NUM_REQ_DEF        = 4;
    localparam int unsigned DATA_BITS_DEF      = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1_000_000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_t;

    // Index following idx in a ring of n entries.
    function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward
// from ptr with wrap-around; one-hot winner plus valid.
module uart_rr_pick
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    always_comb begin
        int unsigned idx;
        logic [PTR_W-1:0] sel;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = idx[PTR_W-1:0];
            if (!valid && req[sel]) begin
                winner[sel] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between NUM_REQ requesters: round-robin grant, one
// character in flight, and a watchdog that aborts a transfer lacking tx_done.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
    parameter int unsigned DATA_BITS      = DATA_BITS_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_done,
    input  logic                           tx_busy,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sched_state_t             state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [PTR_W-1:0]         owner_q, owner_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]       done_q, done_d;
    logic                     tx_start_q, tx_start_d;
    logic [DATA_BITS-1:0]     tx_data_q, tx_data_d;
    logic                     busy_q, busy_d;
    logic                     timeout_q, timeout_d;

    logic [NUM_REQ-1:0]       pick_winner;
    logic                     pick_valid;
    logic [PTR_W-1:0]         win_idx;
    logic [DATA_BITS-1:0]     data_arr [NUM_REQ];
    logic                     in_wait;
    logic                     wd_live;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_BITS +: DATA_BITS];
    end

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_winner[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    // Watchdog has not yet fired for the current transfer.
    assign in_wait = (state_q == WAIT_DONE);
    assign wd_live = (cnt_q != CNT_MAX);

    // State register and all datapath/output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic. A watchdog abort pulses while still in WAIT_DONE,
    // so the exit happens one cycle after the pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (pick_valid) state_d = GRANT;
            GRANT:     state_d = START;
            START:     if (tx_start_q) state_d = WAIT_DONE;
            WAIT_DONE: if (!wd_live || tx_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Registered outputs, capture and bookkeeping.
    always_comb begin
        grant_d    = '0;
        done_d     = '0;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        tx_data_d  = tx_data_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = '0;
        busy_d     = (state_d != IDLE);

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d   = pick_winner;
                    tx_data_d = data_arr[win_idx];
                    owner_d   = win_idx;
                end
            end
            GRANT: begin
                tx_start_d = !tx_busy;
            end
            START: begin
                if (!tx_start_q) begin
                    tx_start_d = !tx_busy;
                end
            end
            WAIT_DONE: begin
                cnt_d = wd_live ? cnt_q + CNT_W'(1) : cnt_q;
            end
            default: begin
            end
        endcase

        if (in_wait && wd_live && (tx_done || cnt_q == CNT_LAST)) begin
            done_d[owner_q] = 1'b1;
            timeout_d       = !tx_done;
            ptr_d           = PTR_W'(wrap_next(32'(owner_q), NUM_REQ));
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler
// (NUM_REQ=4, DATA_BITS=8, TIMEOUT_CYCLES=16).
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        tx_busy;
    logic        busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    uart_tx_scheduler #(
        .NUM_REQ        (4),
        .DATA_BITS      (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .done        (done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // After this returns, outputs reflect the new cycle and inputs set now
    // are sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req     = 4'b0000;
        tx_done = 1'b0;
        tx_busy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Full transfer for one requester with no checks; ends in the done cycle.
    task automatic do_xfer(input int idx, input logic [7:0] d);
        req = 4'b0001 << idx;
        req_data[idx*8 +: 8] = d;
        tick();
        req = 4'b0000;
        tick();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        req_data = 32'hDEAD_BEEF;
        do_reset();
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL reset_done got=%b exp=0000", done); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    endtask

    task automatic test_single();
        do_reset();
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        tick();
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", grant); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_early_start got=%b exp=0", tx_start); end
        req = 4'b0000;
        tick();
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_tx_start got=%b exp=1", tx_start); end
        total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_tx_data got=%h exp=a5", tx_data); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_grant_pulse got=%b exp=0000", grant); end
        tick();
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_pulse got=%b exp=0", tx_start); end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL single_done got=%b exp=0001", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL single_done_pulse got=%b exp=0000", done); end
        total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_tx_data_hold got=%h exp=a5", tx_data); end
    endtask

    task automatic test_contention();
        logic [7:0] cdat [4];
        logic [3:0] eg;
        bit found;
        int exp_idx;
        cdat = '{8'h10, 8'h21, 8'h32, 8'h43};
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = cdat[i];
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_idx = k % 4;
            eg = 4'b0001 << exp_idx;
            found = 1'b0;
            for (int n = 0; n < 8 && !found; n++) begin
                tick();
                if (grant !== 4'b0000) found = 1'b1;
            end
            total++; if (!found) begin bad++; $display("FAIL cont_grant_timeout k=%0d got=none exp=%b", k, eg); end
            total++; if (grant !== eg) begin bad++; $display("FAIL cont_grant k=%0d got=%b exp=%b", k, grant, eg); end
            total++; if (tx_data !== cdat[exp_idx]) begin bad++; $display("FAIL cont_tx_data k=%0d got=%h exp=%h", k, tx_data, cdat[exp_idx]); end
            total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL cont_start_overlap k=%0d got=%b exp=0", k, tx_start); end
            if (k == 4) req = 4'b0000;
            tick();
            total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL cont_tx_start k=%0d got=%b exp=1", k, tx_start); end
            tick();
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            total++; if (done !== eg) begin bad++; $display("FAIL cont_done k=%0d got=%b exp=%b", k, done, eg); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        do_xfer(2, 8'h11);
        req_data[7:0]   = 8'h3C;
        req_data[23:16] = 8'h5A;
        req = 4'b0101;
        tick();
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL wrap_grant0 got=%b exp=0001", grant); end
        total++; if (tx_data !== 8'h3C) begin bad++; $display("FAIL wrap_data0 got=%h exp=3c", tx_data); end
        tick();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL wrap_done0 got=%b exp=0001", done); end
        tick();
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL wrap_grant2 got=%b exp=0100", grant); end
        total++; if (tx_data !== 8'h5A) begin bad++; $display("FAIL wrap_data2 got=%h exp=5a", tx_data); end
        req = 4'b0000;
        tick();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        total++; if (done !== 4'b0100) begin bad++; $display("FAIL wrap_done2 got=%b exp=0100", done); end
    endtask

    task automatic test_busy_hold();
        bit early;
        int pulses;
        do_reset();
        tx_busy = 1'b1;
        req_data[7:0] = 8'h77;
        req = 4'b0001;
        tick();
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL busy_grant got=%b exp=0001", grant); end
        req = 4'b0000;
        early = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (tx_start !== 1'b0) early = 1'b1;
        end
        tx_busy = 1'b0;
        total++; if (early) begin bad++; $display("FAIL busy_early_start got=1 exp=0"); end
        tick();
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL busy_tx_start got=%b exp=1", tx_start); end
        total++; if (tx_data !== 8'h77) begin bad++; $display("FAIL busy_tx_data got=%h exp=77", tx_data); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (tx_start === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL busy_extra_pulses got=%0d exp=0", pulses); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL busy_done got=%b exp=0001", done); end
    endtask

    task automatic test_timeout();
        bit early;
        do_reset();
        req_data[15:8] = 8'h99;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        tick();
        early = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (timeout_err !== 1'b0 || done !== 4'b0000) early = 1'b1;
        end
        total++; if (early) begin bad++; $display("FAIL to_early got=1 exp=0"); end
        tick();
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b exp=1", timeout_err); end
        total++; if (done !== 4'b0010) begin bad++; $display("FAIL to_done got=%b exp=0010", done); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy_hold got=%b exp=1", busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy_fall got=%b exp=0", busy); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_pulse_len got=%b exp=0", timeout_err); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL to_stray_done got=%b exp=0000", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_stray_busy got=%b exp=0", busy); end
        req = 4'b0110;
        tick();
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL to_ptr_adv got=%b exp=0100", grant); end
        req = 4'b0000;
        tick();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        total++; if (done !== 4'b0100) begin bad++; $display("FAIL to_next_done got=%b exp=0100", done); end
    endtask

    task automatic test_drop();
        int stray;
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        tick();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL drop_done got=%b exp=0001", done); end
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (grant !== 4'b0000 || busy !== 1'b0) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL drop_stray_grant got=%0d exp=0", stray); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_xfer(1, 8'h22);
        req_data[23:16] = 8'h5E;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tx_done = 1'b1;
        req = 4'b1111;
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL rmid_done got=%b exp=0000", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (grant !== 4'b0000 || tx_start !== 1'b0 || timeout_err !== 1'b0) begin
            bad++; $display("FAIL rmid_outputs got=%b/%b/%b exp=0000/0/0", grant, tx_start, timeout_err);
        end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rmid_tx_data got=%h exp=00", tx_data); end
        rst = 1'b0;
        tx_done = 1'b0;
        req = 4'b0000;
        tick();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL rmid_late_done got=%b exp=0000", done); end
        req = 4'b0110;
        tick();
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL rmid_regrant got=%b exp=0010", grant); end
        req = 4'b0000;
        tick();
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL rmid_tx_start got=%b exp=1", tx_start); end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        total++; if (done !== 4'b0010) begin bad++; $display("FAIL rmid_done_after got=%b exp=0010", done); end
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        req_data = '0;
        tx_done  = 1'b0;
        tx_busy  = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_busy_hold();
        test_timeout();
        test_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
